// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID-stage fields, MEM/WB bypass sources and the
// registered EX-stage outputs. The pipeline front end is master, the stage is slave.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;

  logic [4:0]      mem_rd;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [4:0]      wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_result;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            ex_illegal;
  logic [XLEN-1:0] ex_A;
  logic [XLEN-1:0] ex_B;
  logic [3:0]      ex_ALUcontrol;
  logic [XLEN-1:0] ex_rs2_fwd;

  modport master (
    output stall, flush, id_valid, id_pc, id_opcode, id_funct3, id_funct7_5,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    input  ex_valid, ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_illegal, ex_A, ex_B, ex_ALUcontrol, ex_rs2_fwd
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_opcode, id_funct3, id_funct7_5,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    output ex_valid, ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, ex_illegal, ex_A, ex_B, ex_ALUcontrol, ex_rs2_fwd
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-code decode, stall/flush and operand select.
// Define ID_EX_FORWARD_EN to enable MEM/WB bypass onto the operands and store data.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_UNS = 4'b1111;

  typedef enum logic [1:0] {A_RS = 2'b00, A_PC = 2'b01, A_ZERO = 2'b10} a_sel_e;
  typedef enum logic {B_RS = 1'b0, B_IMM = 1'b1} b_sel_e;

  logic            ex_valid_q, reg_write_q, mem_read_q, mem_write_q, branch_q, illegal_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rd_q;
  logic [3:0]      alu_q;
  a_sel_e          a_sel_q;
  b_sel_e          b_sel_q;
  logic [XLEN-1:0] rs1_val, rs2_val;

  logic       d_reg_write, d_mem_read, d_mem_write, d_branch, d_illegal;
  logic [3:0] d_alu;
  a_sel_e     d_a_sel;
  b_sel_e     d_b_sel;

  // Only R-type distinguishes SUB; shifts use bit 30 for both R and I forms.
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic f7_5,
                                         input logic is_r);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_UNS;
    endcase
    return code;
  endfunction

  always_comb begin
    d_alu       = ALU_UNS;
    d_illegal   = 1'b1;
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch    = 1'b0;
    d_a_sel     = A_RS;
    d_b_sel     = B_RS;
    case (bus.id_opcode)
      OP_R, OP_I: begin
        d_alu       = alu_map(bus.id_funct3, bus.id_funct7_5, bus.id_opcode == OP_R);
        d_illegal   = (d_alu == ALU_UNS);
        d_reg_write = !d_illegal;
        d_b_sel     = (bus.id_opcode == OP_I) ? B_IMM : B_RS;
      end
      OP_LOAD: begin
        d_alu = ALU_ADD; d_illegal = 1'b0; d_b_sel = B_IMM;
        d_mem_read = 1'b1; d_reg_write = 1'b1;
      end
      OP_STORE: begin
        d_alu = ALU_ADD; d_illegal = 1'b0; d_b_sel = B_IMM; d_mem_write = 1'b1;
      end
      OP_BR: begin
        d_alu = ALU_SUB; d_illegal = 1'b0; d_branch = 1'b1;
      end
      OP_LUI: begin
        d_alu = ALU_ADD; d_illegal = 1'b0; d_a_sel = A_ZERO; d_b_sel = B_IMM;
        d_reg_write = 1'b1;
      end
      OP_AUIPC: begin
        d_alu = ALU_ADD; d_illegal = 1'b0; d_a_sel = A_PC; d_b_sel = B_IMM;
        d_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ID_EX_FORWARD_EN
  logic [4:0] rs1_q, rs2_q;

  function automatic logic [XLEN-1:0] bypass(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] v;
    if (bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == rs)
      v = bus.mem_result;
    else if (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == rs)
      v = bus.wb_result;
    else
      v = rf;
    return v;
  endfunction

  assign rs1_val = bypass(rs1_q, rs1_data_q);
  assign rs2_val = bypass(rs2_q, rs2_data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (!bus.flush && !bus.stall && bus.id_valid) begin
      rs1_q <= bus.id_rs1;
      rs2_q <= bus.id_rs2;
    end
  end
`else
  assign rs1_val = rs1_data_q;
  assign rs2_val = rs2_data_q;
`endif

  // Bubbles clear controls and rd but leave the datapath registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
      alu_q       <= ALU_ADD;
      rd_q        <= '0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      a_sel_q     <= A_RS;
      b_sel_q     <= B_RS;
    end else if (bus.flush || (!bus.stall && !bus.id_valid)) begin
      ex_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
      alu_q       <= ALU_ADD;
      rd_q        <= '0;
    end else if (bus.stall) begin
`ifdef ID_EX_FORWARD_EN
      // Keep results that retire while we are held.
      rs1_data_q <= rs1_val;
      rs2_data_q <= rs2_val;
`endif
    end else begin
      ex_valid_q  <= 1'b1;
      reg_write_q <= d_reg_write;
      mem_read_q  <= d_mem_read;
      mem_write_q <= d_mem_write;
      branch_q    <= d_branch;
      illegal_q   <= d_illegal;
      alu_q       <= d_alu;
      rd_q        <= bus.id_rd;
      pc_q        <= bus.id_pc;
      rs1_data_q  <= bus.id_rs1_data;
      rs2_data_q  <= bus.id_rs2_data;
      imm_q       <= bus.id_imm;
      a_sel_q     <= d_a_sel;
      b_sel_q     <= d_b_sel;
    end
  end

  always_comb begin
    case (a_sel_q)
      A_PC:    bus.ex_A = pc_q;
      A_ZERO:  bus.ex_A = '0;
      default: bus.ex_A = rs1_val;
    endcase
  end

  assign bus.ex_B          = (b_sel_q == B_IMM) ? imm_q : rs2_val;
  assign bus.ex_rs2_fwd    = rs2_val;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_branch     = branch_q;
  assign bus.ex_illegal    = illegal_q;
  assign bus.ex_ALUcontrol = alu_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues hand-computed EX outputs per
// edge, a negedge monitor pops and compares. Works with or without ID_EX_FORWARD_EN.
module tb_id_ex_stage;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, ill;
    logic [3:0]  alu;
    logic [31:0] a, b, rs2f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  exp_t sb_q[$];

  id_ex_stage_if #(.XLEN(32)) bus ();
  id_ex_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw, input logic br,
                              input logic ill, input logic [3:0] alu, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] rs2f);
    exp_t e;
    e.valid = v; e.pc = pc; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.br = br;
    e.ill = ill; e.alu = alu; e.a = a; e.b = b; e.rs2f = rs2f;
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e);
    exp_t g;
    g = mk(bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read,
           bus.ex_mem_write, bus.ex_branch, bus.ex_illegal, bus.ex_ALUcontrol,
           bus.ex_A, bus.ex_B, bus.ex_rs2_fwd);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got v=%0b pc=%h rd=%0d rw%0b mr%0b mw%0b br%0b ill%0b alu=%b A=%h B=%h st=%h | want v=%0b pc=%h rd=%0d rw%0b mr%0b mw%0b br%0b ill%0b alu=%b A=%h B=%h st=%h",
               name, g.valid, g.pc, g.rd, g.rw, g.mr, g.mw, g.br, g.ill, g.alu, g.a, g.b, g.rs2f,
               e.valid, e.pc, e.rd, e.rw, e.mr, e.mw, e.br, e.ill, e.alu, e.a, e.b, e.rs2f);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      compare($sformatf("txn%0d", txn), e);
      txn++;
    end
  end

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [6:0] opc,
                        input logic [2:0] f3, input logic f7, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm);
    bus.id_valid = v; bus.id_pc = pc; bus.id_opcode = opc; bus.id_funct3 = f3;
    bus.id_funct7_5 = f7; bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_rd = rd;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
  endtask

  // One edge; bypass sources then change and stay valid until the next edge.
  task automatic cyc(input exp_t e, input logic [4:0] mrd, input logic mrw,
                     input logic [31:0] mres, input logic [4:0] wrd, input logic wrw,
                     input logic [31:0] wres);
    @(posedge clk);
    #1;
    bus.mem_rd = mrd; bus.mem_reg_write = mrw; bus.mem_result = mres;
    bus.wb_rd = wrd; bus.wb_reg_write = wrw; bus.wb_result = wres;
    sb_q.push_back(e);
  endtask

  task automatic cyc0(input exp_t e);
    cyc(e, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  exp_t zero_e, add_e, bub_e, hold_e;

  initial begin
    zero_e = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    set_id(0, 0, 7'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
    bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_result = 0;
    #3 compare("reset_state", zero_e);
    #9 rst_n = 1'b1;

    set_id(1, 32'h40, OP_R, 3'b000, 1, 1, 2, 3, 10, 10, 0);
    cyc0(mk(1, 32'h40, 3, 1, 0, 0, 0, 0, 4'b0001, 10, 10, 10));
    set_id(1, 32'h44, OP_R, 3'b101, 1, 1, 2, 4, 32'h80000000, 4, 0);
    cyc0(mk(1, 32'h44, 4, 1, 0, 0, 0, 0, 4'b0111, 32'h80000000, 4, 4));
    set_id(1, 32'h48, OP_I, 3'b000, 1, 1, 2, 5, 10, 32'h99, 5);
    cyc0(mk(1, 32'h48, 5, 1, 0, 0, 0, 0, 4'b0000, 10, 5, 32'h99));
    set_id(1, 32'h4c, OP_I, 3'b101, 1, 1, 0, 6, 32'hF0, 0, 2);
    cyc0(mk(1, 32'h4c, 6, 1, 0, 0, 0, 0, 4'b0111, 32'hF0, 2, 0));
    set_id(1, 32'h50, OP_LUI, 0, 0, 7, 0, 7, 32'h55, 32'h66, 32'h12345000);
    cyc0(mk(1, 32'h50, 7, 1, 0, 0, 0, 0, 4'b0000, 0, 32'h12345000, 32'h66));
    set_id(1, 32'h100, OP_AUIPC, 0, 0, 0, 0, 8, 32'h55, 32'h66, 32'h10);
    cyc0(mk(1, 32'h100, 8, 1, 0, 0, 0, 0, 4'b0000, 32'h100, 32'h10, 32'h66));
    set_id(1, 32'h104, OP_LOAD, 3'b010, 0, 1, 0, 9, 32'h200, 0, 8);
    cyc0(mk(1, 32'h104, 9, 1, 1, 0, 0, 0, 4'b0000, 32'h200, 8, 0));
    set_id(1, 32'h108, OP_STORE, 3'b010, 0, 1, 2, 0, 32'h300, 32'hDEAD, 4);
    cyc0(mk(1, 32'h108, 0, 0, 0, 1, 0, 0, 4'b0000, 32'h300, 4, 32'hDEAD));
    set_id(1, 32'h10c, OP_BR, 3'b000, 0, 1, 2, 0, 7, 3, 32'hFFFFFFF0);
    cyc0(mk(1, 32'h10c, 0, 0, 0, 0, 1, 0, 4'b0001, 7, 3, 3));

    // Stall holds, stall+flush bubbles, invalid ID bubbles.
    add_e = mk(1, 32'h120, 5, 1, 0, 0, 0, 0, 4'b0000, 1, 2, 2);
    bub_e = mk(0, 32'h120, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 2, 2);
    set_id(1, 32'h120, OP_R, 3'b000, 0, 1, 2, 5, 1, 2, 0);
    cyc0(add_e);
    bus.stall = 1'b1;
    set_id(1, 32'h200, OP_R, 3'b000, 1, 3, 4, 6, 9, 9, 0);
    for (int i = 0; i < 3; i++) cyc0(add_e);
    bus.flush = 1'b1;
    cyc0(bub_e);
    bus.stall = 1'b0; bus.flush = 1'b0;
    set_id(0, 32'h300, OP_R, 3'b000, 1, 3, 4, 6, 9, 9, 0);
    cyc0(bub_e);

    set_id(1, 32'h130, OP_R, 3'b011, 0, 1, 2, 7, 5, 6, 0);
    cyc0(mk(1, 32'h130, 7, 0, 0, 0, 0, 1, 4'b1111, 5, 6, 6));
    set_id(1, 32'h134, 7'h7F, 3'b000, 0, 1, 2, 7, 8, 9, 3);
    cyc0(mk(1, 32'h134, 7, 0, 0, 0, 0, 1, 4'b1111, 8, 9, 9));
    bus.flush = 1'b1;
    set_id(1, 32'h138, OP_R, 3'b000, 0, 1, 2, 7, 4, 4, 0);
    cyc0(mk(0, 32'h134, 0, 0, 0, 0, 0, 0, 4'b0000, 8, 9, 9));
    bus.flush = 1'b0;

    // Bypass priority and rd=0 exclusion.
    set_id(1, 32'h140, OP_R, 3'b000, 0, 5, 6, 10, 32'h11, 32'h22, 0);
    cyc(mk(1, 32'h140, 10, 1, 0, 0, 0, 0, 4'b0000, FWD ? 32'hAA : 32'h11, 32'h22, 32'h22),
        5, 1, 32'hAA, 5, 1, 32'hBB);
    set_id(1, 32'h144, OP_R, 3'b000, 0, 5, 6, 10, 32'h11, 32'h22, 0);
    cyc(mk(1, 32'h144, 10, 1, 0, 0, 0, 0, 4'b0000, FWD ? 32'hBB : 32'h11, 32'h22, 32'h22),
        0, 1, 32'hAA, 5, 1, 32'hBB);
    set_id(1, 32'h148, OP_R, 3'b000, 0, 5, 6, 10, 32'h11, 32'h22, 0);
    cyc(mk(1, 32'h148, 10, 1, 0, 0, 0, 0, 4'b0000, FWD ? 32'hBB : 32'h11, 32'h22, 32'h22),
        5, 0, 32'hAA, 5, 1, 32'hBB);
    set_id(1, 32'h14c, OP_R, 3'b000, 0, 0, 6, 10, 32'h11, 32'h22, 0);
    cyc(mk(1, 32'h14c, 10, 1, 0, 0, 0, 0, 4'b0000, 32'h11, 32'h22, 32'h22),
        0, 1, 32'hAA, 0, 1, 32'hBB);

    // WB result retiring during a stall must survive the stall.
    hold_e = mk(1, 32'h150, 8, 1, 0, 0, 0, 0, 4'b0000, 3,
                FWD ? 32'h77 : 32'h10, FWD ? 32'h77 : 32'h10);
    set_id(1, 32'h150, OP_R, 3'b000, 0, 1, 7, 8, 3, 32'h10, 0);
    cyc(hold_e, 0, 0, 0, 7, 1, 32'h77);
    bus.stall = 1'b1;
    set_id(1, 32'h400, OP_R, 3'b000, 1, 2, 3, 4, 5, 6, 7);
    cyc0(hold_e);
    cyc0(hold_e);

    // Asynchronous reset while stalled, away from any edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 compare("async_reset", zero_e);
    #1 rst_n = 1'b1;
    cyc0(zero_e);
    bus.stall = 1'b0;

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
